// File: rtl/dec_sop_pkg.sv
// Shared types for the dec_sop_sweep decoder / sum-of-minterms evaluator.
package dec_sop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/dec_nx2n.sv
// Combinational N-to-2^N one-hot decoder with active-high enable.
module dec_nx2n #(
  parameter int unsigned N = 2
) (
  input  logic                en,
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   y
);

  localparam int unsigned M = 1 << N;

  assign y = en ? (M'(1) << sel) : '0;

endmodule

// File: rtl/dec_sop_sweep.sv
// Registered N-to-2^N decoder with SOP output and a truth-table sweep engine.
// Define DEC_SOP_NEG_OUT_EN for an active-low dec_out (all-ones when disabled).
module dec_sop_sweep
  import dec_sop_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic [(1<<N)-1:0]   mask,
  input  logic                start,
  output logic [(1<<N)-1:0]   dec_out,
  output logic                f,
  output logic [N-1:0]        code,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   tt
);

  localparam int unsigned M  = 1 << N;
  localparam int unsigned CW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [N-1:0]  CODE_TOP = N'(M - 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(STEP - 1);
`ifdef DEC_SOP_NEG_OUT_EN
  localparam logic NEG = 1'b1;
`else
  localparam logic NEG = 1'b0;
`endif
  localparam logic [M-1:0] DEC_OFF = {M{NEG}};

  state_t         state_q, state_d;
  logic [M-1:0]   mask_q, mask_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   tt_q, tt_d;
  logic [M-1:0]   dec_q, dec_d;
  logic           f_q, f_d;
  logic [N-1:0]   code_q, code_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   dec_sel;
  logic           dec_en;
  logic [M-1:0]   dec_y;
  logic [M-1:0]   dec_phys;

  // Decoder input mux: external sel in DIRECT, code 0 on sweep start, next code mid-sweep.
  always_comb begin
    dec_sel = sel;
    dec_en  = en;
    if (state_q == SWEEP) begin
      dec_sel = code_q + N'(1);
      dec_en  = 1'b1;
    end else if (mode == MODE_SWEEP) begin
      dec_sel = '0;
      dec_en  = 1'b1;
    end
  end

  dec_nx2n #(.N(N)) u_dec (
    .en  (dec_en),
    .sel (dec_sel),
    .y   (dec_y)
  );

  assign dec_phys = NEG ? ~dec_y : dec_y;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    dec_d   = dec_q;
    f_d     = f_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mode == MODE_DIRECT) begin
          dec_d  = dec_phys;
          f_d    = en & mask[sel];
          code_d = sel;
        end else if (en && start) begin
          state_d = SWEEP;
          mask_d  = mask;
          tt_d    = '0;
          code_d  = '0;
          cnt_d   = '0;
          dec_d   = dec_phys;
          f_d     = mask[0];
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        // Losing enable abandons the sweep; tt keeps what was captured so far.
        if (!en) begin
          state_d = IDLE;
          dec_d   = DEC_OFF;
          f_d     = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_TOP) begin
          tt_d[code_q] = mask_q[code_q];
          if (code_q == CODE_TOP) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            code_d = code_q + N'(1);
            dec_d  = dec_phys;
            f_d    = mask_q[code_d];
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      dec_q   <= DEC_OFF;
      f_q     <= 1'b0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      dec_q   <= dec_d;
      f_q     <= f_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dec_out = dec_q;
  assign f       = f_q;
  assign code    = code_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tt      = tt_q;

endmodule

// File: tb/tb_dec_sop_sweep.sv
// Bench for dec_sop_sweep: three instances (N=2/STEP=1, N=4/STEP=1, N=2/STEP=3)
// checked every cycle against a time-based model plus directed literal expectations.
module tb_dec_sop_sweep;

`ifdef DEC_SOP_NEG_OUT_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_v[3];
  logic        mode_v[3];
  logic        start_v[3];
  logic [3:0]  sel_v[3];
  logic [15:0] mask_v[3];

  logic [3:0]  d0_dec, d0_tt, d2_dec, d2_tt;
  logic [15:0] d1_dec, d1_tt;
  logic [1:0]  d0_code, d2_code;
  logic [3:0]  d1_code;
  logic        d0_f, d1_f, d2_f, d0_busy, d1_busy, d2_busy, d0_done, d1_done, d2_done;

  dec_sop_sweep #(.N(2), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .mode(mode_v[0]), .sel(sel_v[0][1:0]),
    .mask(mask_v[0][3:0]), .start(start_v[0]), .dec_out(d0_dec), .f(d0_f),
    .code(d0_code), .busy(d0_busy), .done(d0_done), .tt(d0_tt));

  dec_sop_sweep #(.N(4), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .mode(mode_v[1]), .sel(sel_v[1]),
    .mask(mask_v[1]), .start(start_v[1]), .dec_out(d1_dec), .f(d1_f),
    .code(d1_code), .busy(d1_busy), .done(d1_done), .tt(d1_tt));

  dec_sop_sweep #(.N(2), .STEP(3)) u2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .mode(mode_v[2]), .sel(sel_v[2][1:0]),
    .mask(mask_v[2][3:0]), .start(start_v[2]), .dec_out(d2_dec), .f(d2_f),
    .code(d2_code), .busy(d2_busy), .done(d2_done), .tt(d2_tt));

  logic [15:0] a_dec[3], a_tt[3], a_code[3];
  logic        a_f[3], a_busy[3], a_done[3];
  assign a_dec[0] = 16'(d0_dec);  assign a_dec[1] = d1_dec;  assign a_dec[2] = 16'(d2_dec);
  assign a_tt[0]  = 16'(d0_tt);   assign a_tt[1]  = d1_tt;   assign a_tt[2]  = 16'(d2_tt);
  assign a_code[0] = 16'(d0_code); assign a_code[1] = 16'(d1_code); assign a_code[2] = 16'(d2_code);
  assign a_f[0] = d0_f;       assign a_f[1] = d1_f;       assign a_f[2] = d2_f;
  assign a_busy[0] = d0_busy; assign a_busy[1] = d1_busy; assign a_busy[2] = d2_busy;
  assign a_done[0] = d0_done; assign a_done[1] = d1_done; assign a_done[2] = d2_done;

  int nn[3] = '{2, 4, 2};
  int st[3] = '{1, 1, 3};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] wm(input int k);
    return 16'((1 << (1 << nn[k])) - 1);
  endfunction

  // Physical dec_out for a logical one-hot value (inverted when active-low).
  function automatic logic [15:0] phys(input int k, input logic [15:0] v);
    return NEG ? (~v & wm(k)) : v;
  endfunction

  // Model: 0 idle, 1 sweeping, 2 done; sweep position is edges elapsed since start.
  int          ms[3], mt[3];
  logic [15:0] mmask[3], mtt[3], mdec[3];
  logic [3:0]  mcode[3];
  logic        mf[3], mbusy[3], mdone[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ms[k] = 0; mt[k] = 0; mmask[k] = '0; mtt[k] = '0; mdec[k] = '0;
      mcode[k] = '0; mf[k] = 1'b0; mbusy[k] = 1'b0; mdone[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    int m;
    m = 1 << nn[k];
    case (ms[k])
      0: begin
        if (!mode_v[k]) begin
          mcode[k] = sel_v[k] & 4'(m - 1);
          mdec[k]  = en_v[k] ? (16'(1) << mcode[k]) : 16'(0);
          mf[k]    = en_v[k] & mask_v[k][mcode[k]];
        end else if (en_v[k] && start_v[k]) begin
          ms[k] = 1; mt[k] = 0; mmask[k] = mask_v[k] & wm(k); mtt[k] = '0;
          mcode[k] = '0; mdec[k] = 16'(1); mf[k] = mask_v[k][0]; mbusy[k] = 1'b1;
        end
      end
      1: begin
        if (!en_v[k]) begin
          ms[k] = 0; mdec[k] = '0; mf[k] = 1'b0; mbusy[k] = 1'b0;
        end else begin
          mt[k]++;
          mtt[k] = mmask[k] & 16'((1 << (mt[k] / st[k])) - 1);
          if (mt[k] == m * st[k]) begin
            ms[k] = 2; mbusy[k] = 1'b0; mdone[k] = 1'b1;
          end else begin
            mcode[k] = 4'(mt[k] / st[k]);
            mdec[k]  = 16'(1) << mcode[k];
            mf[k]    = mmask[k][mcode[k]];
          end
        end
      end
      default: begin
        ms[k] = 0; mdone[k] = 1'b0;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else for (int k = 0; k < 3; k++) model_edge(k);
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.dec_out", k), 32'(a_dec[k]), 32'(phys(k, mdec[k])));
      chk($sformatf("u%0d.f", k),       32'(a_f[k]),   32'(mf[k]));
      chk($sformatf("u%0d.code", k),    32'(a_code[k]), 32'(mcode[k]));
      chk($sformatf("u%0d.busy", k),    32'(a_busy[k]), 32'(mbusy[k]));
      chk($sformatf("u%0d.done", k),    32'(a_done[k]), 32'(mdone[k]));
      chk($sformatf("u%0d.tt", k),      32'(a_tt[k]),  32'(mtt[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] t1_dec[4] = '{16'h1, 16'h2, 16'h4, 16'h8};
  logic        t1_f[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int de, nb;
    for (int k = 0; k < 3; k++) begin
      en_v[k] = 1'b0; mode_v[k] = 1'b0; start_v[k] = 1'b0; sel_v[k] = '0; mask_v[k] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Test 1: DIRECT decode, mask 1010
    en_v[0] = 1'b1; mask_v[0] = 16'hA;
    for (int s = 0; s < 4; s++) begin
      sel_v[0] = 4'(s);
      tick();
      chk("t1_dec", 32'(a_dec[0]), 32'(phys(0, t1_dec[s])));
      chk("t1_f", 32'(a_f[0]), 32'(t1_f[s]));
    end

    // Test 2: DIRECT with enable low
    en_v[0] = 1'b0; sel_v[0] = 4'd2;
    tick();
    chk("t2_dec", 32'(a_dec[0]), 32'(phys(0, 16'h0)));
    chk("t2_f", 32'(a_f[0]), 32'd0);
    chk("t2_busy", 32'(a_busy[0]), 32'd0);
    chk("t2_done", 32'(a_done[0]), 32'd0);

    // Test 3: full N=4 sweep of F=A(CD+B)+BC'
    en_v[1] = 1'b1; mode_v[1] = 1'b1; mask_v[1] = 16'hF830; start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    chk("t3_busy0", 32'(a_busy[1]), 32'd1);
    de = 0; nb = 1;
    for (int i = 1; i <= 40 && de == 0; i++) begin
      tick();
      if (a_done[1]) de = i;
      else if (a_busy[1]) nb++;
    end
    chk("t3_done_edge", 32'(de), 32'd16);
    chk("t3_busy_cycles", 32'(nb), 32'd16);
    chk("t3_tt", 32'(a_tt[1]), 32'h0000F830);
    tick();
    chk("t3_done_clr", 32'(a_done[1]), 32'd0);

    // Test 4: STEP=3, start and mask changes mid-sweep are ignored
    en_v[2] = 1'b1; mode_v[2] = 1'b1; mask_v[2] = 16'h6; start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    de = 0;
    for (int i = 1; i <= 40 && de == 0; i++) begin
      tick();
      if (i == 2)  chk("t4_code_i2", 32'(a_code[2]), 32'd0);
      if (i == 3)  chk("t4_code_i3", 32'(a_code[2]), 32'd1);
      if (i == 11) chk("t4_code_i11", 32'(a_code[2]), 32'd3);
      if (i == 4) begin start_v[2] = 1'b1; mask_v[2] = 16'hF; end
      if (i == 5) start_v[2] = 1'b0;
      if (a_done[2]) de = i;
    end
    chk("t4_done_edge", 32'(de), 32'd12);
    chk("t4_tt", 32'(a_tt[2]), 32'h6);

    // Test 5: enable dropped while code 5 is presented
    mask_v[1] = 16'hF830; start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (5) tick();
    chk("t5_code5", 32'(a_code[1]), 32'd5);
    en_v[1] = 1'b0;
    tick();
    chk("t5_busy", 32'(a_busy[1]), 32'd0);
    chk("t5_dec", 32'(a_dec[1]), 32'(phys(1, 16'h0)));
    chk("t5_tt", 32'(a_tt[1]), 32'h0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_done", 32'(a_done[1]), 32'd0);
    end

    // Test 6: asynchronous reset mid-sweep, then a clean sweep
    en_v[1] = 1'b1; start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    chk("t6_dec", 32'(a_dec[1]), 32'(phys(1, 16'h0)));
    chk("t6_f", 32'(a_f[1]), 32'd0);
    chk("t6_code", 32'(a_code[1]), 32'd0);
    chk("t6_busy", 32'(a_busy[1]), 32'd0);
    chk("t6_tt", 32'(a_tt[1]), 32'd0);
    chk("t6_u2_tt", 32'(a_tt[2]), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    de = 0;
    for (int i = 1; i <= 40 && de == 0; i++) begin
      tick();
      if (a_done[1]) de = i;
    end
    chk("t6_done_edge", 32'(de), 32'd16);
    chk("t6_tt_after", 32'(a_tt[1]), 32'h0000F830);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
